// File: rtl/uart_rx_ctrl.sv
// UART receiver: start detect, 3-sample majority vote per bit, LSB-first deserialize, parity/stop check.
// Define UART_RX_INPUT_SYNC_EN to pass rx_in through a 2-flop synchronizer (adds 2 cycles of latency).
//
// state    | meaning
// S_IDLE   | line idle, waiting for a low level
// S_START  | timing the start bit; a high majority sample means glitch, back to idle
// S_DATA   | shifting in DATA_WIDTH payload bits
// S_PARITY | checking the parity bit (only when par_en was latched high)
// S_STOP   | checking the stop bit, releasing the byte on a clean frame
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESC_W-1:0]    prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state, state_nx;
    logic                  rx_s;
    logic [PRESC_W-1:0]    presc_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic [PRESC_W-1:0]    edge_cnt;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [1:0]            samp_q;
    logic                  bit_val;
    logic [DATA_WIDTH-1:0] shift;
    logic                  done_q;

    logic [PRESC_W-1:0]    half;
    logic                  end_bit;
    logic                  last_bit;
    logic                  start_det;
    logic                  frame_start;
    logic                  cnt_run;
    logic                  shift_en;
    logic                  par_chk;
    logic                  stp_chk;
    logic                  frame_good;

`ifdef UART_RX_INPUT_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_in};
        end
    end

    assign rx_s = sync_q[1];
`else
    assign rx_s = rx_in;
`endif

    assign half     = presc_q >> 1;
    assign end_bit  = (edge_cnt == presc_q - 1'b1);
    assign last_bit = (bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (!rx_s) state_nx = S_START;
            S_START:  if (end_bit) state_nx = bit_val ? S_IDLE : S_DATA;
            S_DATA:   if (end_bit && last_bit) state_nx = par_en_q ? S_PARITY : S_STOP;
            S_PARITY: if (end_bit) state_nx = S_STOP;
            S_STOP:   if (end_bit) state_nx = rx_s ? S_IDLE : S_START;
            default:  state_nx = S_IDLE;
        endcase
    end

    // A low line at the end of a stop bit is taken as the next start bit (back-to-back frames).
    always_comb begin
        start_det   = (state == S_IDLE) && !rx_s;
        frame_start = start_det || ((state == S_STOP) && end_bit && !rx_s);
        cnt_run     = (state != S_IDLE);
        shift_en    = (state == S_DATA) && end_bit;
        par_chk     = (state == S_PARITY) && end_bit;
        stp_chk     = (state == S_STOP) && end_bit;
        frame_good  = stp_chk && bit_val && !(par_en_q && par_err);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else if (frame_start) begin
            presc_q   <= prescale;
            par_en_q  <= par_en;
            par_typ_q <= par_typ;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            if (frame_start || !cnt_run || end_bit) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= edge_cnt + 1'b1;
            end
            if (frame_start) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp_q  <= 2'b00;
            bit_val <= 1'b0;
        end else if (cnt_run) begin
            if (edge_cnt == half - 1'b1) samp_q[0] <= rx_s;
            if (edge_cnt == half) samp_q[1] <= rx_s;
            if (edge_cnt == half + 1'b1) begin
                bit_val <= (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift <= '0;
        end else if (shift_en) begin
            shift <= {bit_val, shift[DATA_WIDTH-1:1]};
        end
    end

    // Flags survive a back-to-back restart so a frame break stays visible; an idle start clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_err <= 1'b0;
            stp_err <= 1'b0;
        end else begin
            if (start_det) begin
                par_err <= 1'b0;
            end else if (par_chk) begin
                par_err <= ((^shift) ^ par_typ_q) != bit_val;
            end
            if (start_det) begin
                stp_err <= 1'b0;
            end else if (stp_chk) begin
                stp_err <= ~bit_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q     <= 1'b0;
            data_valid <= 1'b0;
            p_data     <= '0;
        end else begin
            done_q     <= frame_good;
            data_valid <= done_q;
            if (done_q) p_data <= shift;
        end
    end

endmodule
